global_mem_arbiter: RTL and testbench

GLOBAL_MEM_ARBITER -- requirements
Module: global_mem_arbiter

---
 rtl/global_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_global_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/global_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : global_mem_arbiter
// Purpose  : Shared global memory for two cores. A three-state lock FSM
//            (IDLE / OWN0 / OWN1) decides which core may write. Both cores
//            always get an independent registered read port.
//
// Ports    : clk                    - sole clock, rising edge
//            rst                    - synchronous reset, active low
//            need_lock_0/1          - lock request from core 0 / core 1
//            gaddress_0/1           - word address from core 0 / core 1
//            gdata_0/1              - write data from core 0 / core 1
//            gwren_0/1              - write enable from core 0 / core 1
//            lock_0/1               - stall to core 0 / core 1 (1 = wait)
//            gq_0/1                 - registered read data, one-cycle latency
//            owner                  - 00 none, 01 core 0, 10 core 1
//            conflict               - sticky, a write was dropped
//            timeout                - sticky, a lock was revoked
//
// Options  : GMEM_LOCK_TIMEOUT_EN   - bounds lock hold time to TIMEOUT_CYCLES
//                                     and revokes the lock when it expires
//
// Revision : 1.0 - initial release
// ============================================================================
module global_mem_arbiter #(
    parameter int ADDR_W         = 6,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              need_lock_0,
    input  logic              need_lock_1,
    input  logic [ADDR_W-1:0] gaddress_0,
    input  logic [ADDR_W-1:0] gaddress_1,
    input  logic [DATA_W-1:0] gdata_0,
    input  logic [DATA_W-1:0] gdata_1,
    input  logic              gwren_0,
    input  logic              gwren_1,
    output logic              lock_0,
    output logic              lock_1,
    output logic [DATA_W-1:0] gq_0,
    output logic [DATA_W-1:0] gq_1,
    output logic [1:0]        owner,
    output logic              conflict,
    output logic              timeout
);

    // State encoding doubles as the owner output code.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    localparam int C_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [C_DEPTH];
    state_t            r_state;
    state_t            w_next;
    logic              r_last_owner;
    logic [DATA_W-1:0] r_gq_0;
    logic [DATA_W-1:0] r_gq_1;
    logic              r_conflict;

    logic              w_req_0;
    logic              w_req_1;
    logic              w_hit_0;
    logic              w_hit_1;
    logic              w_rev_0;
    logic              w_rev_1;

    logic              w_we;
    logic              w_drop;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

`ifdef GMEM_LOCK_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_CNT_W-1:0] r_hold_cnt;
    logic               w_at_limit;
    logic               r_rev_0;
    logic               r_rev_1;
    logic               r_timeout;

    // The owning cycle that would bring the count to TIMEOUT_CYCLES is the
    // last one; revocation only applies if the owner still wants the lock.
    assign w_at_limit = (r_state != ST_IDLE) &&
                        (r_hold_cnt == C_CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_hit_0    = w_at_limit && (r_state == ST_OWN0) && need_lock_0;
    assign w_hit_1    = w_at_limit && (r_state == ST_OWN1) && need_lock_1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold_cnt <= '0;
            r_rev_0    <= 1'b0;
            r_rev_1    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_hold_cnt <= '0;
            end else if (r_state != ST_IDLE) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            // A revoked core stays stalled until it drops its request.
            if (w_hit_0) begin
                r_rev_0 <= 1'b1;
            end else if (!need_lock_0) begin
                r_rev_0 <= 1'b0;
            end
            if (w_hit_1) begin
                r_rev_1 <= 1'b1;
            end else if (!need_lock_1) begin
                r_rev_1 <= 1'b0;
            end

            if (w_hit_0 || w_hit_1) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_rev_0 = r_rev_0;
    assign w_rev_1 = r_rev_1;
    assign timeout = r_timeout;
`else
    assign w_hit_0 = 1'b0;
    assign w_hit_1 = 1'b0;
    assign w_rev_0 = 1'b0;
    assign w_rev_1 = 1'b0;
    assign timeout = 1'b0;
`endif

    // Revoked cores are invisible to the grant logic.
    assign w_req_0 = need_lock_0 && !w_rev_0;
    assign w_req_1 = need_lock_1 && !w_rev_1;

    // ---------------- lock FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == ST_OWN0 && w_next != ST_OWN0) begin
                r_last_owner <= 1'b0;
            end else if (r_state == ST_OWN1 && w_next != ST_OWN1) begin
                r_last_owner <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // Simultaneous requests alternate away from the last owner.
                if (w_req_0 && w_req_1) begin
                    w_next = r_last_owner ? ST_OWN0 : ST_OWN1;
                end else if (w_req_0) begin
                    w_next = ST_OWN0;
                end else if (w_req_1) begin
                    w_next = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!need_lock_0 || w_hit_0) begin
                    w_next = w_req_1 ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!need_lock_1 || w_hit_1) begin
                    w_next = w_req_0 ? ST_OWN0 : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign owner  = r_state;
    assign lock_0 = (need_lock_0 && (r_state != ST_OWN0)) || w_rev_0;
    assign lock_1 = (need_lock_1 && (r_state != ST_OWN1)) || w_rev_1;

    // ---------------- write arbitration ----------------
    // At most one write per cycle reaches the array, so one write port.
    always_comb begin
        w_we    = 1'b0;
        w_drop  = 1'b0;
        w_waddr = gaddress_0;
        w_wdata = gdata_0;
        case (r_state)
            ST_OWN0: begin
                w_we   = gwren_0;
                w_drop = gwren_1;
            end
            ST_OWN1: begin
                w_we    = gwren_1;
                w_waddr = gaddress_1;
                w_wdata = gdata_1;
                w_drop  = gwren_0;
            end
            default: begin
                if (gwren_0) begin
                    w_we   = 1'b1;
                    w_drop = gwren_1;
                end else if (gwren_1) begin
                    w_we    = 1'b1;
                    w_waddr = gaddress_1;
                    w_wdata = gdata_1;
                end
            end
        endcase
    end

    // Array is deliberately not reset; a write in a reset cycle is blocked.
    always_ff @(posedge clk) begin
        if (rst && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Non-blocking reads pick up the pre-write contents (read-before-write).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gq_0     <= '0;
            r_gq_1     <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_gq_0 <= r_mem[gaddress_0];
            r_gq_1 <= r_mem[gaddress_1];
            if (w_drop) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign gq_0     = r_gq_0;
    assign gq_1     = r_gq_1;
    assign conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_global_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_global_mem_arbiter
// Purpose  : Scoreboard bench for global_mem_arbiter. A driver applies
//            directed and random cycles, predicts the outputs seen during
//            each cycle from a behavioural model and queues them; a monitor
//            compares the DUT against the queue in the middle of each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_global_mem_arbiter;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int TMO = 4;
`ifdef GMEM_LOCK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          need_lock_0, need_lock_1;
    logic [AW-1:0] gaddress_0, gaddress_1;
    logic [DW-1:0] gdata_0, gdata_1;
    logic          gwren_0, gwren_1;
    logic          lock_0, lock_1;
    logic [DW-1:0] gq_0, gq_1;
    logic [1:0]    owner;
    logic          conflict;
    logic          timeout;

    global_mem_arbiter #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .need_lock_0(need_lock_0),
        .need_lock_1(need_lock_1),
        .gaddress_0 (gaddress_0),
        .gaddress_1 (gaddress_1),
        .gdata_0    (gdata_0),
        .gdata_1    (gdata_1),
        .gwren_0    (gwren_0),
        .gwren_1    (gwren_1),
        .lock_0     (lock_0),
        .lock_1     (lock_1),
        .gq_0       (gq_0),
        .gq_1       (gq_1),
        .owner      (owner),
        .conflict   (conflict),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    owner;
        logic          l0;
        logic          l1;
        logic [DW-1:0] q0;
        logic [DW-1:0] q1;
        logic          cf;
        logic          to;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: owner 0 = none, 1 = core 0, 2 = core 1.
    int            m_own;
    int            m_last;
    int            m_hold;
    bit            m_valid = 1'b0;
    bit            m_cf, m_to, m_rev0, m_rev1;
    logic [DW-1:0] m_q0, m_q1;
    logic [DW-1:0] m_mem [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: the DUT presents a response every cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("owner",    32'(owner),    32'(mon_e.owner));
            check("lock_0",   32'(lock_0),   32'(mon_e.l0));
            check("lock_1",   32'(lock_1),   32'(mon_e.l1));
            check("gq_0",     gq_0,          mon_e.q0);
            check("gq_1",     gq_1,          mon_e.q1);
            check("conflict", 32'(conflict), 32'(mon_e.cf));
            check("timeout",  32'(timeout),  32'(mon_e.to));
        end
    end

    // One clock cycle of stimulus: drive, queue the prediction, advance model.
    task automatic step(input logic r, input logic nl0, input logic nl1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic w0, input logic w1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        exp_t e;
        bit   g0, g1, hit;
        int   nxt;
        @(posedge clk);
        #2;
        rst = r; need_lock_0 = nl0; need_lock_1 = nl1;
        gaddress_0 = a0; gaddress_1 = a1;
        gwren_0 = w0; gwren_1 = w1; gdata_0 = d0; gdata_1 = d1;

        if (m_valid) begin
            e.owner = 2'(m_own);
            e.l0    = (nl0 && m_own != 1) || m_rev0;
            e.l1    = (nl1 && m_own != 2) || m_rev1;
            e.q0    = m_q0;
            e.q1    = m_q1;
            e.cf    = m_cf;
            e.to    = m_to;
            sb.push_back(e);
        end

        if (!r) begin
            m_own = 0; m_last = 1; m_hold = 0;
            m_q0 = '0; m_q1 = '0;
            m_cf = 0; m_to = 0; m_rev0 = 0; m_rev1 = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_q0 = m_mem[a0];
            m_q1 = m_mem[a1];
            if (m_own == 1) begin
                if (w0) m_mem[a0] = d0;
                if (w1) m_cf = 1;
            end else if (m_own == 2) begin
                if (w1) m_mem[a1] = d1;
                if (w0) m_cf = 1;
            end else begin
                if (w0) m_mem[a0] = d0;
                else if (w1) m_mem[a1] = d1;
                if (w0 && w1) m_cf = 1;
            end

            g0  = nl0 && !m_rev0;
            g1  = nl1 && !m_rev1;
            hit = TMO_EN && m_own != 0 && m_hold == TMO - 1 && (m_own == 1 ? nl0 : nl1);
            nxt = m_own;
            if (m_own == 0) begin
                if (g0 && g1)  nxt = (m_last == 1) ? 1 : 2;
                else if (g0)   nxt = 1;
                else if (g1)   nxt = 2;
            end else if (m_own == 1) begin
                if (!nl0 || hit) nxt = g1 ? 2 : 0;
            end else begin
                if (!nl1 || hit) nxt = g0 ? 1 : 0;
            end
            if (m_own != 0 && nxt != m_own) m_last = m_own - 1;
            if (!nl0) m_rev0 = 0;
            if (!nl1) m_rev1 = 0;
            if (hit) begin
                m_to = 1;
                if (m_own == 1) m_rev0 = 1;
                else            m_rev1 = 1;
            end
            m_hold = (nxt != m_own) ? 0 : ((m_own != 0) ? m_hold + 1 : 0);
            m_own  = nxt;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        rst = 0; need_lock_0 = 0; need_lock_1 = 0;
        gaddress_0 = '0; gaddress_1 = '0; gdata_0 = '0; gdata_1 = '0;
        gwren_0 = 0; gwren_1 = 0;

        // Reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single request, one-cycle grant
        repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Simultaneous requests, hand-over, alternation
        repeat (2) step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Write conflict while core 0 owns the lock
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 5, 5, 1, 1, 32'hDEADBEEF, 32'h12345678);
        step(1, 1, 0, 0, 5, 0, 0, 0, 0);
        step(1, 0, 0, 0, 5, 0, 0, 0, 0);

        // Read-before-write on the top address
        step(1, 0, 0, 63, 0, 1, 0, 32'hA5A5A5A5, 0);
        step(1, 0, 0, 63, 63, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Two writers in IDLE: core 0 wins
        step(1, 0, 0, 7, 7, 1, 1, 32'h11111111, 32'h22222222);
        step(1, 0, 0, 7, 7, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset during OWN1 with a pending write
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 9, 9, 0, 1, 0, 32'hCAFEF00D);
        step(1, 0, 0, 9, 9, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Long hold with core 1 waiting
        repeat (7) step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic; narrow address window some of the time for collisions
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] ra0, ra1;
            ra0 = ($urandom % 2 == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ra1 = ($urandom % 2 == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            step(($urandom % 50) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
                 ra0, ra1, ($urandom % 3) == 0, ($urandom % 3) == 0,
                 DW'($urandom), DW'($urandom));
        end

        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
